// File: rtl/core_dispatch_socket.sv
// Instruction FIFO feeding NUM_CORES matrix cores over a shared bus, with per-core busy tracking,
// round-robin any-free dispatch, explicit targeting, broadcast and barrier synchronisation.
module core_dispatch_socket #(
    parameter int NUM_CORES = 4,
    parameter int INST_W    = 32,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [INST_W-1:0]        inst_data,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [INST_W-1:0]        core_inst,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic [NUM_CORES-1:0]     core_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     idle,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CORES);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {S_RUN, S_SYNC} state_t;

    logic [INST_W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count;
    logic [CW-1:0]        r_rr_ptr;
    state_t               r_state;
    logic [NUM_CORES-1:0] r_start, r_busy;
    logic [INST_W-1:0]    r_inst;
    logic                 r_err;

    logic                 w_empty, w_full, w_push, w_pop, w_bad_id, w_id_ok, w_any_found;
    logic [INST_W-1:0]    w_head;
    logic [1:0]           w_mode;
    logic [3:0]           w_id;
    logic [CW-1:0]        w_id_idx, w_any_sel, w_rr_nxt;
    logic [NUM_CORES-1:0] w_start_nxt;
    state_t               w_state_nxt;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return CW'(s);
    endfunction

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    assign w_push   = inst_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_mode   = w_head[INST_W-1:INST_W-2];
    assign w_id     = w_head[INST_W-3 -: 4];
    assign w_id_ok  = ({1'b0, w_id} < 5'(NUM_CORES));
    assign w_id_idx = CW'(w_id);

    // First free core at or after the round-robin pointer, wrapping around
    always_comb begin
        w_any_found = 1'b0;
        w_any_sel   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!w_any_found && !r_busy[wrap_add(r_rr_ptr, k)]) begin
                w_any_found = 1'b1;
                w_any_sel   = wrap_add(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_pop       = 1'b0;
        w_start_nxt = '0;
        w_rr_nxt    = r_rr_ptr;
        w_bad_id    = 1'b0;
        w_state_nxt = r_state;
        if (!w_empty) begin
            if (r_state == S_RUN) begin
                case (w_mode)
                    2'b00: begin
                        if (w_any_found) begin
                            w_pop                  = 1'b1;
                            w_start_nxt[w_any_sel] = 1'b1;
                            w_rr_nxt               = wrap_add(w_any_sel, 1);
                        end
                    end
                    2'b01: begin
                        if (!w_id_ok) begin
                            w_pop    = 1'b1;
                            w_bad_id = 1'b1;
                        end else if (!r_busy[w_id_idx]) begin
                            w_pop                 = 1'b1;
                            w_start_nxt[w_id_idx] = 1'b1;
                        end
                    end
                    default: w_state_nxt = S_SYNC;
                endcase
            end else if (r_busy == '0) begin
                // Broadcast starts every core; barrier just retires the head
                w_pop       = 1'b1;
                w_state_nxt = S_RUN;
                if (!w_mode[0]) w_start_nxt = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= inst_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            r_state  <= S_RUN;
            r_start  <= '0;
            r_busy   <= '0;
            r_inst   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_rr_ptr <= w_rr_nxt;
            r_state  <= w_state_nxt;
            r_start  <= w_start_nxt;
            if (|w_start_nxt) r_inst <= w_head;
            r_busy   <= (r_busy & ~core_done) | w_start_nxt;
            if (w_bad_id || |(core_done & ~r_busy)) r_err <= 1'b1;
        end
    end

    assign inst_ready = !w_full;
    assign core_start = r_start;
    assign core_inst  = r_inst;
    assign core_busy  = r_busy;
    assign fifo_count = r_count;
    assign idle       = w_empty && (r_busy == '0) && (r_state == S_RUN);
    assign err        = r_err;
endmodule

// File: tb/tb_core_dispatch_socket.sv
// Bench for core_dispatch_socket: a scoreboard of expected {core_start, core_inst} pairs is filled
// as instructions are driven and drained whenever a start pulse appears.
module tb_core_dispatch_socket;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst_data = '0;
    logic [3:0]  core_start;
    logic [31:0] core_inst;
    logic [3:0]  core_done = '0;
    logic [3:0]  core_busy;
    logic [3:0]  fifo_count;
    logic        idle;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [35:0] sb[$];
    logic [35:0] mon_exp;
    bit sb_en = 1'b0;

    core_dispatch_socket #(.NUM_CORES(4), .INST_W(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .core_start(core_start), .core_inst(core_inst),
        .core_done(core_done), .core_busy(core_busy), .fifo_count(fifo_count),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (sb_en && core_start !== 4'b0000) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL dispatch: unexpected start %b inst %h, none expected", core_start, core_inst);
            end else begin
                mon_exp = sb.pop_front();
                if ({core_start, core_inst} !== mon_exp)
                    $display("FAIL dispatch: got start %b inst %h, expected start %b inst %h",
                             core_start, core_inst, mon_exp[35:32], mon_exp[31:0]);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] mode, input logic [3:0] id, input logic [7:0] tag);
        return {mode, id, 18'd0, tag};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        inst_valid = 1'b1;
        inst_data  = d;
        while (!inst_ready && n < 50) begin
            cyc(1);
            n++;
        end
        if (!inst_ready) begin
            n_checks++;
            $display("FAIL push_timeout: inst_ready still %b after 50 cycles, expected 1", inst_ready);
        end
        cyc(1);
        inst_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] m);
        core_done = m;
        cyc(1);
        core_done = 4'b0000;
    endtask

    task automatic do_reset();
        inst_valid = 1'b0;
        core_done  = 4'b0000;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (fifo_count !== 4'd0) $display("FAIL rst_count: got %0d expected 0", fifo_count); else n_pass++;
        n_checks++; if (inst_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", inst_ready); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b expected 1", idle); else n_pass++;
        n_checks++; if (core_busy !== 4'b0000) $display("FAIL rst_busy: got %b expected 0000", core_busy); else n_pass++;
        n_checks++; if (core_start !== 4'b0000 || core_inst !== 32'h0)
            $display("FAIL rst_start: got %b/%h expected 0000/0", core_start, core_inst); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else n_pass++;
        // Reset with cores busy, FIFO traffic and err raised
        push(mk(2'b00, 4'd0, 8'h11));
        push(mk(2'b00, 4'd0, 8'h12));
        push(mk(2'b01, 4'd15, 8'h13));
        cyc(2);
        n_checks++; if (core_busy !== 4'b0011 || err !== 1'b1)
            $display("FAIL pre_rst: busy %b err %b expected 0011 1", core_busy, err); else n_pass++;
        push(mk(2'b00, 4'd0, 8'h14));
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (core_start !== 4'b0000 || core_busy !== 4'b0000 || fifo_count !== 4'd0 || idle !== 1'b1 || err !== 1'b0)
            $display("FAIL mid_rst: start %b busy %b count %0d idle %b err %b expected 0000 0000 0 1 0",
                     core_start, core_busy, fifo_count, idle, err);
        else n_pass++;
        cyc(1);
        sb.delete();
        sb_en = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) sb.push_back({4'(1 << i), mk(2'b00, 4'd0, 8'(8'h21 + i))});
        sb.push_back({4'b0010, mk(2'b00, 4'd0, 8'h25)});
        sb.push_back({4'b0001, mk(2'b00, 4'd0, 8'h26)});
        for (int i = 0; i < 6; i++) push(mk(2'b00, 4'd0, 8'(8'h21 + i)));
        cyc(3);
        n_checks++; if (fifo_count !== 4'd2 || core_busy !== 4'b1111)
            $display("FAIL rr_stall: count %0d busy %b expected 2 1111", fifo_count, core_busy); else n_pass++;
        pulse_done(4'b0010);
        cyc(3);
        n_checks++; if (fifo_count !== 4'd1 || core_busy !== 4'b1111)
            $display("FAIL rr_done1: count %0d busy %b expected 1 1111", fifo_count, core_busy); else n_pass++;
        pulse_done(4'b0001);
        cyc(3);
        n_checks++; if (fifo_count !== 4'd0 || sb.size() != 0)
            $display("FAIL rr_done0: count %0d pending %0d expected 0 0", fifo_count, sb.size()); else n_pass++;
        pulse_done(4'b1111);
        cyc(1);
        n_checks++; if (idle !== 1'b1 || core_busy !== 4'b0000)
            $display("FAIL rr_idle: idle %b busy %b expected 1 0000", idle, core_busy); else n_pass++;
    endtask

    task automatic test_explicit();
        sb.push_back({4'b0100, mk(2'b01, 4'd2, 8'h31)});
        sb.push_back({4'b0100, mk(2'b01, 4'd2, 8'h32)});
        sb.push_back({4'b0010, mk(2'b00, 4'd0, 8'h34)});
        push(mk(2'b01, 4'd2, 8'h31));
        push(mk(2'b01, 4'd2, 8'h32));
        cyc(3);
        n_checks++; if (fifo_count !== 4'd1 || core_busy !== 4'b0100)
            $display("FAIL exp_stall: count %0d busy %b expected 1 0100", fifo_count, core_busy); else n_pass++;
        pulse_done(4'b0100);
        cyc(3);
        n_checks++; if (fifo_count !== 4'd0 || core_busy !== 4'b0100 || err !== 1'b0)
            $display("FAIL exp_go: count %0d busy %b err %b expected 0 0100 0", fifo_count, core_busy, err); else n_pass++;
        push(mk(2'b01, 4'd9, 8'h33));
        cyc(2);
        n_checks++; if (fifo_count !== 4'd0 || err !== 1'b1 || core_busy !== 4'b0100)
            $display("FAIL exp_badid: count %0d err %b busy %b expected 0 1 0100", fifo_count, err, core_busy); else n_pass++;
        // Round-robin pointer left at 1 by the previous test; explicit must not move it
        push(mk(2'b00, 4'd0, 8'h34));
        cyc(3);
        n_checks++; if (sb.size() != 0) $display("FAIL exp_rr: pending %0d expected 0", sb.size()); else n_pass++;
        pulse_done(4'b0110);
        cyc(1);
    endtask

    task automatic test_broadcast_barrier();
        do_reset();
        sb.push_back({4'b1000, mk(2'b01, 4'd3, 8'h41)});
        sb.push_back({4'b1111, mk(2'b10, 4'd0, 8'h42)});
        sb.push_back({4'b0001, mk(2'b00, 4'd0, 8'h44)});
        push(mk(2'b01, 4'd3, 8'h41));
        push(mk(2'b10, 4'd0, 8'h42));
        cyc(3);
        n_checks++; if (fifo_count !== 4'd1 || core_busy !== 4'b1000 || idle !== 1'b0)
            $display("FAIL bc_wait: count %0d busy %b idle %b expected 1 1000 0", fifo_count, core_busy, idle); else n_pass++;
        pulse_done(4'b1000);
        cyc(3);
        n_checks++; if (fifo_count !== 4'd0 || core_busy !== 4'b1111)
            $display("FAIL bc_go: count %0d busy %b expected 0 1111", fifo_count, core_busy); else n_pass++;
        push(mk(2'b11, 4'd0, 8'h43));
        push(mk(2'b00, 4'd0, 8'h44));
        pulse_done(4'b0111);
        cyc(3);
        n_checks++; if (fifo_count !== 4'd2 || core_busy !== 4'b1000)
            $display("FAIL bar_hold: count %0d busy %b expected 2 1000", fifo_count, core_busy); else n_pass++;
        pulse_done(4'b1000);
        cyc(4);
        n_checks++; if (fifo_count !== 4'd0 || core_busy !== 4'b0001 || sb.size() != 0)
            $display("FAIL bar_release: count %0d busy %b pending %0d expected 0 0001 0",
                     fifo_count, core_busy, sb.size()); else n_pass++;
        pulse_done(4'b0001);
        cyc(1);
        n_checks++; if (idle !== 1'b1 || err !== 1'b0)
            $display("FAIL bc_idle: idle %b err %b expected 1 0", idle, err); else n_pass++;
    endtask

    task automatic test_fifo_full();
        int n;
        sb.push_back({4'b0010, mk(2'b00, 4'd0, 8'h51)});
        sb.push_back({4'b0100, mk(2'b00, 4'd0, 8'h52)});
        sb.push_back({4'b1000, mk(2'b00, 4'd0, 8'h53)});
        sb.push_back({4'b0001, mk(2'b00, 4'd0, 8'h54)});
        sb.push_back({4'b0100, mk(2'b00, 4'd0, 8'h60)});
        for (int i = 0; i < 4; i++) push(mk(2'b00, 4'd0, 8'(8'h51 + i)));
        for (int i = 0; i < 8; i++) push(mk(2'b00, 4'd0, 8'(8'h60 + i)));
        inst_valid = 1'b1;
        inst_data  = mk(2'b00, 4'd0, 8'h68);
        n_checks++; if (fifo_count !== 4'd8 || inst_ready !== 1'b0)
            $display("FAIL full: count %0d ready %b expected 8 0", fifo_count, inst_ready); else n_pass++;
        cyc(2);
        n_checks++; if (fifo_count !== 4'd8) $display("FAIL full_hold: count %0d expected 8", fifo_count); else n_pass++;
        pulse_done(4'b0100);
        n = 0;
        while (!inst_ready && n < 20) begin
            cyc(1);
            n++;
        end
        n_checks++; if (inst_ready !== 1'b1 || fifo_count !== 4'd7)
            $display("FAIL full_pop: ready %b count %0d expected 1 7", inst_ready, fifo_count); else n_pass++;
        cyc(1);
        inst_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd8 || inst_ready !== 1'b0 || core_busy !== 4'b1111)
            $display("FAIL full_refill: count %0d ready %b busy %b expected 8 0 1111",
                     fifo_count, inst_ready, core_busy); else n_pass++;
        cyc(2);
        n_checks++; if (sb.size() != 0) $display("FAIL full_sb: pending %0d expected 0", sb.size()); else n_pass++;
        do_reset();
    endtask

    task automatic test_spurious_done();
        n_checks++; if (err !== 1'b0 || core_busy !== 4'b0000)
            $display("FAIL sp_pre: err %b busy %b expected 0 0000", err, core_busy); else n_pass++;
        sb.push_back({4'b0001, mk(2'b00, 4'd0, 8'h71)});
        push(mk(2'b00, 4'd0, 8'h71));
        cyc(2);
        pulse_done(4'b0010);
        n_checks++; if (err !== 1'b1 || core_busy !== 4'b0001)
            $display("FAIL sp_err: err %b busy %b expected 1 0001", err, core_busy); else n_pass++;
        pulse_done(4'b0001);
        cyc(2);
        n_checks++; if (err !== 1'b1 || core_busy !== 4'b0000 || sb.size() != 0)
            $display("FAIL sp_sticky: err %b busy %b pending %0d expected 1 0000 0",
                     err, core_busy, sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_explicit();
        test_broadcast_barrier();
        test_fifo_full();
        test_spurious_done();
        cyc(2);
        n_checks++; if (sb.size() != 0) $display("FAIL sb_final: %0d expected dispatches never seen", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
